// File: rtl/alien_formation_ctrl.sv
// Alien formation sequencer: frame-paced stepping, edge reversal with drop, and a registered per-alien coordinate lookup.
// Optional ALIEN_FORM_SPEEDUP_EN shortens the step period as aliens die.
module alien_formation_ctrl #(
    parameter int CORDW    = 16,
    parameter int COLS     = 8,
    parameter int ROWS     = 4,
    parameter int SPR_W    = 16,
    parameter int SPR_H    = 16,
    parameter int GAP_X    = 8,
    parameter int GAP_Y    = 8,
    parameter int STEP_X   = 2,
    parameter int DROP_Y   = 8,
    parameter int SCREEN_W = 640,
    parameter int MARGIN   = 8,
    parameter int START_X  = 64,
    parameter int START_Y  = 48,
    parameter int LAND_Y   = 448
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      frame,
    input  logic                      start,
    input  logic [7:0]                period,
    input  logic [ROWS*COLS-1:0]      alive_mask,
    input  logic [$clog2(COLS)-1:0]   req_col,
    input  logic [$clog2(ROWS)-1:0]   req_row,
    output logic [CORDW-1:0]          spr_x,
    output logic [CORDW-1:0]          spr_y,
    output logic [CORDW-1:0]          form_x,
    output logic [CORDW-1:0]          form_y,
    output logic                      dir_left,
    output logic                      step,
    output logic                      landed,
    output logic                      cleared
);

    localparam logic [CORDW-1:0] PITCH_X   = CORDW'(SPR_W + GAP_X);
    localparam logic [CORDW-1:0] PITCH_Y   = CORDW'(SPR_H + GAP_Y);
    localparam logic [CORDW-1:0] C_SPR_W   = CORDW'(SPR_W);
    localparam logic [CORDW-1:0] C_SPR_H   = CORDW'(SPR_H);
    localparam logic [CORDW-1:0] C_STEP_X  = CORDW'(STEP_X);
    localparam logic [CORDW-1:0] C_DROP_Y  = CORDW'(DROP_Y);
    localparam logic [CORDW-1:0] C_START_X = CORDW'(START_X);
    localparam logic [CORDW-1:0] C_START_Y = CORDW'(START_Y);
    localparam logic [CORDW-1:0] C_LAND_Y  = CORDW'(LAND_Y);
    localparam logic [CORDW-1:0] LEFT_LIM  = CORDW'(MARGIN + STEP_X);
    localparam logic [CORDW-1:0] RIGHT_LIM = CORDW'(SCREEN_W - MARGIN);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_WAIT    = 3'd1,
        S_CHECK   = 3'd2,
        S_MOVE    = 3'd3,
        S_DROP    = 3'd4,
        S_LANDED  = 3'd5,
        S_CLEARED = 3'd6
    } state_t;

    state_t           state_r;
    logic [7:0]       frame_cnt_r;
    logic [7:0]       eff_period_s;
    logic [CORDW-1:0] br_r;
    logic [COLS-1:0]  col_alive_s;
    logic [ROWS-1:0]  row_alive_s;
    logic [CORDW-1:0] lc_s, rc_s, br_s;
    logic [CORDW-1:0] left_edge_s, right_edge_s, drop_y_s, bottom_s;
    logic             any_alive_s, can_move_s, land_s;

    // Surviving column/row extents and edge tests for the current position
    always_comb begin
        col_alive_s = '0;
        row_alive_s = '0;
        for (int r = 0; r < ROWS; r++) begin
            for (int c = 0; c < COLS; c++) begin
                if (alive_mask[r*COLS+c]) begin
                    col_alive_s[c] = 1'b1;
                    row_alive_s[r] = 1'b1;
                end else begin
                    col_alive_s[c] = col_alive_s[c];
                end
            end
        end
        lc_s = '0;
        rc_s = '0;
        br_s = '0;
        for (int c = COLS - 1; c >= 0; c--) begin
            if (col_alive_s[c]) lc_s = CORDW'(c);
            else                lc_s = lc_s;
        end
        for (int c = 0; c < COLS; c++) begin
            if (col_alive_s[c]) rc_s = CORDW'(c);
            else                rc_s = rc_s;
        end
        for (int r = 0; r < ROWS; r++) begin
            if (row_alive_s[r]) br_s = CORDW'(r);
            else                br_s = br_s;
        end
        any_alive_s  = |alive_mask;
        left_edge_s  = form_x + lc_s * PITCH_X;
        right_edge_s = form_x + rc_s * PITCH_X + C_SPR_W;
        if (dir_left) can_move_s = (left_edge_s >= LEFT_LIM);
        else          can_move_s = (right_edge_s + C_STEP_X <= RIGHT_LIM);
        // Bottom row captured at CHECK so a late mask change cannot alter the landing decision
        drop_y_s = form_y + C_DROP_Y;
        bottom_s = drop_y_s + br_r * PITCH_Y + C_SPR_H;
        land_s   = (bottom_s >= C_LAND_Y);
    end

`ifdef ALIEN_FORM_SPEEDUP_EN
    logic [7:0] dead_cnt_r;
    logic [7:0] speedup_s;

    function automatic logic [7:0] popcount(input logic [ROWS*COLS-1:0] v);
        logic [7:0] n;
        n = 8'd0;
        for (int i = 0; i < ROWS*COLS; i++) n = n + {7'd0, v[i]};
        return n;
    endfunction

    // Dead-alien count refreshed while waiting for the next step
    always_ff @(posedge clk) begin
        if (rst)                    dead_cnt_r <= 8'd0;
        else if (state_r == S_WAIT) dead_cnt_r <= 8'(ROWS*COLS) - popcount(alive_mask);
    end

    // Effective period shrinks by one frame per four dead aliens, floor of 1
    always_comb begin
        speedup_s = dead_cnt_r >> 2;
        if (period > speedup_s) eff_period_s = period - speedup_s;
        else                    eff_period_s = 8'd1;
    end
`else
    // Effective period with zero treated as one
    always_comb begin
        if (period == 8'd0) eff_period_s = 8'd1;
        else                eff_period_s = period;
    end
`endif

    // Formation FSM, position registers and coordinate lookup
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= S_IDLE;
            form_x      <= C_START_X;
            form_y      <= C_START_Y;
            dir_left    <= 1'b0;
            step        <= 1'b0;
            landed      <= 1'b0;
            cleared     <= 1'b0;
            spr_x       <= '0;
            spr_y       <= '0;
            frame_cnt_r <= 8'd0;
            br_r        <= '0;
        end else begin
            spr_x <= form_x + CORDW'(req_col) * PITCH_X;
            spr_y <= form_y + CORDW'(req_row) * PITCH_Y;
            step  <= 1'b0;
            if (start) begin
                form_x      <= C_START_X;
                form_y      <= C_START_Y;
                dir_left    <= 1'b0;
                landed      <= 1'b0;
                cleared     <= 1'b0;
                frame_cnt_r <= 8'd0;
                state_r     <= S_WAIT;
            end else begin
                case (state_r)
                    S_IDLE: state_r <= S_IDLE;
                    S_WAIT: begin
                        if (frame) begin
                            if (frame_cnt_r >= eff_period_s - 8'd1) begin
                                frame_cnt_r <= 8'd0;
                                state_r     <= S_CHECK;
                            end else begin
                                frame_cnt_r <= frame_cnt_r + 8'd1;
                            end
                        end
                    end
                    S_CHECK: begin
                        br_r <= br_s;
                        if (!any_alive_s) begin
                            cleared <= 1'b1;
                            state_r <= S_CLEARED;
                        end else if (can_move_s) begin
                            state_r <= S_MOVE;
                        end else begin
                            state_r <= S_DROP;
                        end
                    end
                    S_MOVE: begin
                        form_x  <= dir_left ? form_x - C_STEP_X : form_x + C_STEP_X;
                        step    <= 1'b1;
                        state_r <= S_WAIT;
                    end
                    S_DROP: begin
                        form_y   <= drop_y_s;
                        dir_left <= ~dir_left;
                        step     <= 1'b1;
                        if (land_s) begin
                            landed  <= 1'b1;
                            state_r <= S_LANDED;
                        end else begin
                            state_r <= S_WAIT;
                        end
                    end
                    S_LANDED:  state_r <= S_LANDED;
                    S_CLEARED: state_r <= S_CLEARED;
                    default:   state_r <= S_IDLE;
                endcase
            end
        end
    end

endmodule
